// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use interlock, taken-branch squash and
// multicycle EXECUTE occupancy, plus a saturating stall-cycle counter.
module hazard_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  source1_DECODE,
    input  logic [4:0]  source2_DECODE,
    input  logic [4:0]  store_DECODE,
    input  logic        uses_source1_DECODE,
    input  logic        uses_source2_DECODE,
    input  logic        uses_store_DECODE,
    input  logic        valid_DECODE,
    input  logic [4:0]  destination_DECODE,
    input  logic        writeback_DECODE,
    input  logic        load_DECODE,
    input  logic        multicycle_DECODE,
    input  logic [2:0]  latency_DECODE,
    input  logic        branch_taken_EXECUTE,
    output logic        stall_FETCH,
    output logic        stall_DECODE,
    output logic        bubble_EXECUTE,
    output logic        hold_EXECUTE,
    output logic        flush_DECODE,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_MULTI = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_count;
    logic        r_ex_valid;
    logic [4:0]  r_ex_destination;
    logic        r_ex_load;
    logic        r_ex_writeback;
    logic [15:0] r_stall_cycles;

    logic        w_src_match;
    logic        w_load_use;
    logic        w_issue;
    logic        w_enter_multi;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Hazard detection against the instruction currently in EXECUTE
    always_comb begin
        w_src_match = (uses_source1_DECODE && (source1_DECODE == r_ex_destination)) ||
                      (uses_source2_DECODE && (source2_DECODE == r_ex_destination)) ||
                      (uses_store_DECODE   && (store_DECODE   == r_ex_destination));
        w_load_use  = r_ex_valid && r_ex_load && r_ex_writeback &&
                      (r_ex_destination != 5'd0) && valid_DECODE && w_src_match;
    end

    assign w_issue       = valid_DECODE && !stall_DECODE && !flush_DECODE;
    assign w_enter_multi = w_issue && multicycle_DECODE && (latency_DECODE >= 3'd2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_enter_multi) begin
                    w_next_state = ST_MULTI;
                end
            end
            ST_MULTI: begin
                if (r_count <= 3'd1) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Outputs are gated by reset_n so they drop without waiting for a clock
    always_comb begin
        stall_FETCH    = 1'b0;
        stall_DECODE   = 1'b0;
        bubble_EXECUTE = 1'b0;
        hold_EXECUTE   = 1'b0;
        flush_DECODE   = 1'b0;
        if (reset_n) begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken_EXECUTE) begin
                        flush_DECODE   = 1'b1;
                        bubble_EXECUTE = 1'b1;
                    end else if (w_load_use) begin
                        stall_FETCH    = 1'b1;
                        stall_DECODE   = 1'b1;
                        bubble_EXECUTE = 1'b1;
                    end
                end
                ST_MULTI: begin
                    stall_FETCH  = 1'b1;
                    stall_DECODE = 1'b1;
                    hold_EXECUTE = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count        <= 3'd0;
            r_ex_valid     <= 1'b0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (stall_DECODE) begin
                r_stall_cycles <= sat_inc16(r_stall_cycles);
            end
            if (r_state == ST_MULTI) begin
                if (r_count != 3'd0) begin
                    r_count <= r_count - 3'd1;
                end
            end else begin
                // Anything other than an issue puts a NOP into EXECUTE
                r_ex_valid <= w_issue;
                if (w_enter_multi) begin
                    r_count <= latency_DECODE - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if ((r_state == ST_RUN) && w_issue) begin
            r_ex_destination <= destination_DECODE;
            r_ex_load        <= load_DECODE;
            r_ex_writeback   <= writeback_DECODE;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: load-use, r0, branch priority, multicycle,
// reset in MULTI and stall counter saturation.
module tb_hazard_unit;

    logic        clock;
    logic        reset_n;
    logic [4:0]  source1_DECODE, source2_DECODE, store_DECODE;
    logic        uses_source1_DECODE, uses_source2_DECODE, uses_store_DECODE;
    logic        valid_DECODE;
    logic [4:0]  destination_DECODE;
    logic        writeback_DECODE, load_DECODE, multicycle_DECODE;
    logic [2:0]  latency_DECODE;
    logic        branch_taken_EXECUTE;
    logic        stall_FETCH, stall_DECODE, bubble_EXECUTE, hold_EXECUTE, flush_DECODE;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .source1_DECODE       (source1_DECODE),
        .source2_DECODE       (source2_DECODE),
        .store_DECODE         (store_DECODE),
        .uses_source1_DECODE  (uses_source1_DECODE),
        .uses_source2_DECODE  (uses_source2_DECODE),
        .uses_store_DECODE    (uses_store_DECODE),
        .valid_DECODE         (valid_DECODE),
        .destination_DECODE   (destination_DECODE),
        .writeback_DECODE     (writeback_DECODE),
        .load_DECODE          (load_DECODE),
        .multicycle_DECODE    (multicycle_DECODE),
        .latency_DECODE       (latency_DECODE),
        .branch_taken_EXECUTE (branch_taken_EXECUTE),
        .stall_FETCH          (stall_FETCH),
        .stall_DECODE         (stall_DECODE),
        .bubble_EXECUTE       (bubble_EXECUTE),
        .hold_EXECUTE         (hold_EXECUTE),
        .flush_DECODE         (flush_DECODE),
        .stall_cycles         (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        source1_DECODE = 5'd0; source2_DECODE = 5'd0; store_DECODE = 5'd0;
        uses_source1_DECODE = 1'b0; uses_source2_DECODE = 1'b0; uses_store_DECODE = 1'b0;
        valid_DECODE = 1'b0; destination_DECODE = 5'd0; writeback_DECODE = 1'b0;
        load_DECODE = 1'b0; multicycle_DECODE = 1'b0; latency_DECODE = 3'd0;
        branch_taken_EXECUTE = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] dst, input logic wb);
        clear_in();
        valid_DECODE = 1'b1; destination_DECODE = dst; writeback_DECODE = wb; load_DECODE = 1'b1;
    endtask

    task automatic set_reader(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                              input logic u2, input logic [4:0] st, input logic us);
        clear_in();
        valid_DECODE = 1'b1; destination_DECODE = 5'd6; writeback_DECODE = 1'b1;
        source1_DECODE = s1; uses_source1_DECODE = u1;
        source2_DECODE = s2; uses_source2_DECODE = u2;
        store_DECODE = st;   uses_store_DECODE = us;
    endtask

    task automatic set_multi(input logic [2:0] lat);
        clear_in();
        valid_DECODE = 1'b1; destination_DECODE = 5'd8; writeback_DECODE = 1'b1;
        multicycle_DECODE = 1'b1; latency_DECODE = lat;
    endtask

    initial begin
        clear_in();
        reset_n = 1'b0;
        branch_taken_EXECUTE = 1'b1;
        #2;
        chk("rst_flush", {31'd0, flush_DECODE}, 32'd0);
        chk("rst_bubble", {31'd0, bubble_EXECUTE}, 32'd0);
        tick();
        chk("rst_stall", {31'd0, stall_DECODE}, 32'd0);
        chk("rst_cnt", {16'd0, stall_cycles}, 32'd0);
        clear_in();
        reset_n = 1'b1;

        // Load r5 followed by a reader of r5
        set_load(5'd5, 1'b1);
        #1 chk("a_load_nostall", {31'd0, stall_DECODE}, 32'd0);
        tick();
        set_reader(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #1;
        chk("a_stallF", {31'd0, stall_FETCH}, 32'd1);
        chk("a_stallD", {31'd0, stall_DECODE}, 32'd1);
        chk("a_bubble", {31'd0, bubble_EXECUTE}, 32'd1);
        chk("a_flush", {31'd0, flush_DECODE}, 32'd0);
        tick();
        chk("a_stall_done", {31'd0, stall_DECODE}, 32'd0);
        chk("a_bubble_done", {31'd0, bubble_EXECUTE}, 32'd0);
        chk("a_cnt", {16'd0, stall_cycles}, 32'd1);
        tick();

        // Matching specifiers that are not actually read
        set_load(5'd7, 1'b1);
        tick();
        set_reader(5'd7, 1'b0, 5'd7, 1'b0, 5'd7, 1'b0);
        #1 chk("unused_nostall", {31'd0, stall_DECODE}, 32'd0);
        tick();

        // Load to r0
        set_load(5'd0, 1'b1);
        tick();
        set_reader(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
        #1 chk("r0_nostall", {31'd0, stall_DECODE}, 32'd0);
        tick();

        // Store-data specifier dependence
        set_load(5'd9, 1'b1);
        tick();
        set_reader(5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1);
        #1 chk("st_stall", {31'd0, stall_DECODE}, 32'd1);
        tick();
        chk("st_once", {31'd0, stall_DECODE}, 32'd0);
        chk("st_cnt", {16'd0, stall_cycles}, 32'd2);
        tick();

        // Load without writeback
        set_load(5'd4, 1'b0);
        tick();
        set_reader(5'd0, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0);
        #1 chk("nowb_nostall", {31'd0, stall_DECODE}, 32'd0);
        tick();

        // Load-use coinciding with a taken branch
        set_load(5'd3, 1'b1);
        tick();
        set_reader(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        branch_taken_EXECUTE = 1'b1;
        #1;
        chk("br_flush", {31'd0, flush_DECODE}, 32'd1);
        chk("br_bubble", {31'd0, bubble_EXECUTE}, 32'd1);
        chk("br_stallD", {31'd0, stall_DECODE}, 32'd0);
        chk("br_stallF", {31'd0, stall_FETCH}, 32'd0);
        tick();
        branch_taken_EXECUTE = 1'b0;
        #1;
        chk("br_cleared", {31'd0, stall_DECODE}, 32'd0);
        chk("br_cnt", {16'd0, stall_cycles}, 32'd2);
        tick();

        // Multicycle latency 4: three stall/hold cycles, branch ignored
        set_multi(3'd4);
        #1 chk("m_issue_nostall", {31'd0, stall_DECODE}, 32'd0);
        tick();
        set_reader(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        branch_taken_EXECUTE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("m_stallD", {31'd0, stall_DECODE}, 32'd1);
            chk("m_stallF", {31'd0, stall_FETCH}, 32'd1);
            chk("m_hold", {31'd0, hold_EXECUTE}, 32'd1);
            chk("m_bubble", {31'd0, bubble_EXECUTE}, 32'd0);
            chk("m_flush", {31'd0, flush_DECODE}, 32'd0);
            tick();
        end
        chk("m_end_stall", {31'd0, stall_DECODE}, 32'd0);
        chk("m_end_hold", {31'd0, hold_EXECUTE}, 32'd0);
        chk("m_end_flush", {31'd0, flush_DECODE}, 32'd1);
        chk("m_cnt", {16'd0, stall_cycles}, 32'd5);
        branch_taken_EXECUTE = 1'b0;
        tick();

        // Latency 1 is single-cycle
        set_multi(3'd1);
        tick();
        set_reader(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        #1;
        chk("lat1_stall", {31'd0, stall_DECODE}, 32'd0);
        chk("lat1_hold", {31'd0, hold_EXECUTE}, 32'd0);
        tick();

        // Reset mid-MULTI at count 2
        set_multi(3'd4);
        tick();
        clear_in();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("mr_stallF", {31'd0, stall_FETCH}, 32'd0);
        chk("mr_stallD", {31'd0, stall_DECODE}, 32'd0);
        chk("mr_hold", {31'd0, hold_EXECUTE}, 32'd0);
        chk("mr_bubble", {31'd0, bubble_EXECUTE}, 32'd0);
        chk("mr_flush", {31'd0, flush_DECODE}, 32'd0);
        chk("mr_cnt", {16'd0, stall_cycles}, 32'd0);
        tick();
        reset_n = 1'b1;
        set_reader(5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        #1;
        chk("mr_run_stall", {31'd0, stall_DECODE}, 32'd0);
        chk("mr_run_hold", {31'd0, hold_EXECUTE}, 32'd0);
        tick();
        chk("mr_run_cnt", {16'd0, stall_cycles}, 32'd0);

        // Back-to-back latency-7 ops: 6 stalls per 7 cycles
        set_multi(3'd7);
        for (int i = 0; i < 70; i++) tick();
        chk("sat_partial", {16'd0, stall_cycles}, 32'd60);
        for (int i = 0; i < 76450; i++) tick();
        chk("sat_full", {16'd0, stall_cycles}, 32'h0000FFFF);
        for (int i = 0; i < 10; i++) tick();
        chk("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports source1_DECODE, source2_DECODE, store_DECODE  input  5 each  register specifiers of the instruction in DECODE.
REQ-004 SHALL have ports uses_source1_DECODE, uses_source2_DECODE, uses_store_DECODE  input  1 each  the corresponding specifier is actually read.
REQ-005 SHALL have port valid_DECODE  input  1  DECODE holds a real instruction.
REQ-006 SHALL have ports destination_DECODE  input  5 and writeback_DECODE  input  1  target register and register-write enable of the DECODE instruction.
REQ-007 SHALL have port load_DECODE  input  1  DECODE instruction is a load; its result is not forwardable until MEMORY.
REQ-008 SHALL have ports multicycle_DECODE  input  1 and latency_DECODE  input  3  DECODE instruction occupies EXECUTE for latency_DECODE cycles.
REQ-009 SHALL have port branch_taken_EXECUTE  input  1  EXECUTE resolved a taken branch.
REQ-010 SHALL have ports stall_FETCH, stall_DECODE  output  1 each  hold the PC and the IF/ID register.
REQ-011 SHALL have ports bubble_EXECUTE, hold_EXECUTE, flush_DECODE  output  1 each  load a NOP into ID/EX; keep ID/EX unchanged; squash the IF/ID contents.
REQ-012 SHALL have port stall_cycles  output  16  saturating count of cycles with stall_DECODE=1.

Function
REQ-013 SHALL keep an internal EXECUTE shadow (ex_valid, ex_destination, ex_load, ex_writeback), a 3-bit counter count, and a two-state FSM {RUN, MULTI}.
REQ-014 SHALL define issue = valid_DECODE & ~stall_DECODE & ~flush_DECODE.
REQ-015 SHALL define load_use = ex_valid & ex_load & ex_writeback & (ex_destination != 0) & valid_DECODE & (any used DECODE specifier equals ex_destination).
REQ-016 In RUN with branch_taken_EXECUTE=1, SHALL assert flush_DECODE and bubble_EXECUTE, deassert both stall outputs even when load_use=1, and clear ex_valid next cycle.
REQ-017 In RUN with no taken branch and load_use=1, SHALL assert stall_FETCH, stall_DECODE and bubble_EXECUTE combinationally in that cycle and clear ex_valid next cycle; the stall lasts exactly one cycle.
REQ-018 On issue, SHALL load the shadow from valid_DECODE, destination_DECODE, load_DECODE and writeback_DECODE.
REQ-019 On issue with multicycle_DECODE=1 and latency_DECODE >= 2, SHALL move to MULTI with count <= latency_DECODE - 1; latency 0 or 1 SHALL be treated as single-cycle.
REQ-020 In MULTI, SHALL assert stall_FETCH, stall_DECODE and hold_EXECUTE, deassert bubble_EXECUTE and flush_DECODE, ignore branch_taken_EXECUTE, and retain the shadow.
REQ-021 In MULTI, SHALL decrement count each cycle and return to RUN on the edge where count == 1, leaving count 0.
REQ-022 SHALL increment stall_cycles on every edge with stall_DECODE=1 and saturate it at 16'hFFFF.
REQ-023 Register 0 SHALL never cause a load-use stall.

Reset
REQ-024 While reset_n=0, SHALL force FSM=RUN, count=0, ex_valid=0, stall_cycles=0 and all 1-bit outputs to 0, independent of clock.
REQ-025 Reset asserted in MULTI SHALL abandon the multicycle operation; the first post-reset cycle SHALL start in RUN with no stall.

Verification
REQ-026 Load issued with destination r5, next DECODE reads source1=r5 -> one cycle of stall_FETCH=stall_DECODE=bubble_EXECUTE=1, then issue; stall_cycles=1.
REQ-027 Load with destination r0, next instruction reads r0 -> no stall.
REQ-028 Multicycle issue with latency_DECODE=4 -> stall and hold_EXECUTE high for exactly 3 cycles, then RUN.
REQ-029 load_use and branch_taken_EXECUTE in the same cycle -> flush_DECODE=1, bubble_EXECUTE=1, stall_DECODE=0.
REQ-030 reset_n pulsed low mid-MULTI with count=2 -> all outputs 0 immediately; RUN and stall_cycles=0 afterward.
REQ-031 Force 65540 stall cycles -> stall_cycles holds 16'hFFFF.
